// File: rtl/sampler_audio_pkg.sv
// Shared defaults, types and helpers for the sampler playback audio path.
package sampler_audio_pkg;

    localparam int I2S_DATA_WIDTH = 24;
    localparam int I2S_SLOT_WIDTH = 32;
    localparam int UNDERRUN_CNT_W = 16;

    typedef struct packed {
        logic [I2S_DATA_WIDTH-1:0] left;
        logic [I2S_DATA_WIDTH-1:0] right;
    } stereo_sample_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [UNDERRUN_CNT_W-1:0] sat_inc(input logic [UNDERRUN_CNT_W-1:0] value);
        logic [UNDERRUN_CNT_W-1:0] result;
        if (value == {UNDERRUN_CNT_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + UNDERRUN_CNT_W'(1);
        end
        return result;
    endfunction

endpackage

// File: rtl/i2s_clock_gen.sv
// I2S timing: bclk divider, slot bit counter, word clock and frame strobes.
// fall_evt_s / frame_evt_s / bit_cnt_nxt_s are combinational look-aheads
// so the data path can register its bit in the same edge as bclk falls.
module i2s_clock_gen #(
    parameter int SLOT_WIDTH       = 32,
    parameter int BCLK_HALF_PERIOD = 8
) (
    input  logic                            board_clk,
    input  logic                            reset,
    input  logic                            enable,
    output logic                            ac_bclk,
    output logic                            ac_pblrc,
    output logic                            frame_start,
    output logic                            fall_evt_s,
    output logic                            frame_evt_s,
    output logic [$clog2(2*SLOT_WIDTH)-1:0] bit_cnt_nxt_s
);

    localparam int CNT_W = $clog2(2 * SLOT_WIDTH);
    localparam int DIV_W = $clog2(BCLK_HALF_PERIOD);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(2 * SLOT_WIDTH - 1);
    localparam logic [DIV_W-1:0] DIV_TC   = DIV_W'(BCLK_HALF_PERIOD - 1);

    logic [DIV_W-1:0] div_cnt_r;
    logic [CNT_W-1:0] bit_cnt_r;
    logic             bclk_r;
    logic             pblrc_r;
    logic             frame_start_r;
    logic             tc_s;

    assign tc_s        = (div_cnt_r == DIV_TC);
    assign fall_evt_s  = enable && tc_s && bclk_r;
    assign frame_evt_s = fall_evt_s && (bit_cnt_nxt_s == {CNT_W{1'b0}});

    assign ac_bclk     = bclk_r;
    assign ac_pblrc    = pblrc_r;
    assign frame_start = frame_start_r;

    // Bit index the counter moves to on the next fall event (wraps per frame).
    always_comb begin
        if (bit_cnt_r == LAST_BIT) begin
            bit_cnt_nxt_s = {CNT_W{1'b0}};
        end else begin
            bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
        end
    end

    // Divider, bclk toggle, bit counter, word clock and frame_start pulse.
    always_ff @(posedge board_clk) begin
        if (!reset || !enable) begin
            div_cnt_r     <= {DIV_W{1'b0}};
            bclk_r        <= 1'b0;
            bit_cnt_r     <= LAST_BIT;
            pblrc_r       <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            if (tc_s) begin
                div_cnt_r <= {DIV_W{1'b0}};
                bclk_r    <= !bclk_r;
            end else begin
                div_cnt_r <= div_cnt_r + DIV_W'(1);
                bclk_r    <= bclk_r;
            end
            if (fall_evt_s) begin
                bit_cnt_r     <= bit_cnt_nxt_s;
                pblrc_r       <= (bit_cnt_nxt_s >= CNT_W'(SLOT_WIDTH));
                frame_start_r <= frame_evt_s;
            end else begin
                bit_cnt_r     <= bit_cnt_r;
                pblrc_r       <= pblrc_r;
                frame_start_r <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/i2s_playback_serializer.sv
// I2S playback serializer: one-pair holding buffer, per-frame shift
// registers, MSB-first data mux and underrun accounting.
module i2s_playback_serializer
    import sampler_audio_pkg::*;
#(
    parameter int DATA_WIDTH       = I2S_DATA_WIDTH,
    parameter int SLOT_WIDTH       = I2S_SLOT_WIDTH,
    parameter int BCLK_HALF_PERIOD = 8
) (
    input  logic                      board_clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [DATA_WIDTH-1:0]     s_left,
    input  logic [DATA_WIDTH-1:0]     s_right,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      ac_bclk,
    output logic                      ac_pblrc,
    output logic                      ac_pbdat,
    output logic                      frame_start,
    output logic                      underrun,
    output logic [UNDERRUN_CNT_W-1:0] underrun_count
);

    localparam int CNT_W = $clog2(2 * SLOT_WIDTH);

    logic                      empty_r;
    logic [DATA_WIDTH-1:0]     hold_left_r;
    logic [DATA_WIDTH-1:0]     hold_right_r;
    logic [DATA_WIDTH-1:0]     shift_left_r;
    logic [DATA_WIDTH-1:0]     shift_right_r;
    logic                      pbdat_r;
    logic                      underrun_r;
    logic [UNDERRUN_CNT_W-1:0] underrun_count_r;

    logic                      fall_evt_s;
    logic                      frame_evt_s;
    logic [CNT_W-1:0]          bit_cnt_nxt_s;
    logic                      chan_s;
    logic [CNT_W-1:0]          p_s;
    logic [DATA_WIDTH-1:0]     word_s;
    logic [DATA_WIDTH-1:0]     onehot_s;
    logic                      data_bit_s;

    i2s_clock_gen #(
        .SLOT_WIDTH       (SLOT_WIDTH),
        .BCLK_HALF_PERIOD (BCLK_HALF_PERIOD)
    ) u_clock_gen (
        .board_clk     (board_clk),
        .reset         (reset),
        .enable        (enable),
        .ac_bclk       (ac_bclk),
        .ac_pblrc      (ac_pblrc),
        .frame_start   (frame_start),
        .fall_evt_s    (fall_evt_s),
        .frame_evt_s   (frame_evt_s),
        .bit_cnt_nxt_s (bit_cnt_nxt_s)
    );

    assign s_ready        = empty_r;
    assign ac_pbdat       = pbdat_r;
    assign underrun       = underrun_r;
    assign underrun_count = underrun_count_r;

    // Select the bit for the upcoming slot position: bit 0 is the I2S delay
    // bit, positions 1..DATA_WIDTH walk the sample MSB first, rest pads 0.
    always_comb begin
        chan_s = (bit_cnt_nxt_s >= CNT_W'(SLOT_WIDTH));
        if (chan_s) begin
            p_s    = bit_cnt_nxt_s - CNT_W'(SLOT_WIDTH);
            word_s = shift_right_r;
        end else begin
            p_s    = bit_cnt_nxt_s;
            word_s = shift_left_r;
        end
        onehot_s = DATA_WIDTH'(1) << (CNT_W'(DATA_WIDTH) - p_s);
        if ((p_s >= CNT_W'(1)) && (p_s <= CNT_W'(DATA_WIDTH))) begin
            data_bit_s = |(word_s & onehot_s);
        end else begin
            data_bit_s = 1'b0;
        end
    end

    // Holding register: drained at a frame start, refilled by the handshake.
    // Survives disable; only a reset discards a buffered pair.
    always_ff @(posedge board_clk) begin
        if (!reset) begin
            empty_r      <= 1'b1;
            hold_left_r  <= {DATA_WIDTH{1'b0}};
            hold_right_r <= {DATA_WIDTH{1'b0}};
        end else if (frame_evt_s && !empty_r) begin
            empty_r      <= 1'b1;
            hold_left_r  <= hold_left_r;
            hold_right_r <= hold_right_r;
        end else if (s_valid && empty_r) begin
            empty_r      <= 1'b0;
            hold_left_r  <= s_left;
            hold_right_r <= s_right;
        end else begin
            empty_r      <= empty_r;
            hold_left_r  <= hold_left_r;
            hold_right_r <= hold_right_r;
        end
    end

    // Frame load of the shift registers, serial data bit and underrun pulse.
    always_ff @(posedge board_clk) begin
        if (!reset || !enable) begin
            shift_left_r  <= {DATA_WIDTH{1'b0}};
            shift_right_r <= {DATA_WIDTH{1'b0}};
            pbdat_r       <= 1'b0;
            underrun_r    <= 1'b0;
        end else if (frame_evt_s) begin
            pbdat_r <= 1'b0;
            if (!empty_r) begin
                shift_left_r  <= hold_left_r;
                shift_right_r <= hold_right_r;
                underrun_r    <= 1'b0;
            end else begin
                shift_left_r  <= {DATA_WIDTH{1'b0}};
                shift_right_r <= {DATA_WIDTH{1'b0}};
                underrun_r    <= 1'b1;
            end
        end else if (fall_evt_s) begin
            shift_left_r  <= shift_left_r;
            shift_right_r <= shift_right_r;
            pbdat_r       <= data_bit_s;
            underrun_r    <= 1'b0;
        end else begin
            shift_left_r  <= shift_left_r;
            shift_right_r <= shift_right_r;
            pbdat_r       <= pbdat_r;
            underrun_r    <= 1'b0;
        end
    end

    // Saturating underrun counter; kept across disable.
    always_ff @(posedge board_clk) begin
        if (!reset) begin
            underrun_count_r <= {UNDERRUN_CNT_W{1'b0}};
        end else if (frame_evt_s && empty_r) begin
            underrun_count_r <= sat_inc(underrun_count_r);
        end else begin
            underrun_count_r <= underrun_count_r;
        end
    end

endmodule

// File: doc/i2s_playback_serializer.md
Name: i2s_playback_serializer

Overview:
- Playback-path stage that feeds the audio codec inside sampler_top.
- Accepts stereo PCM pairs from the sample mixer over a valid/ready handshake and buffers one pair.
- Generates the I2S bit clock (ac_bclk) and word clock (ac_pblrc), and serializes the data onto ac_pbdat in standard I2S format (MSB first, one-bclk delay after the LRCLK edge).
- Reports underruns when no sample pair is available at a frame boundary.

Parameters:
DATA_WIDTH, 24, sample width per channel in bits
SLOT_WIDTH, 32, bclk periods per channel slot; must be >= DATA_WIDTH+1
BCLK_HALF_PERIOD, 8, board_clk cycles per half bclk period; must be >= 2

Ports:
board_clk  in  1  system clock; the only clock
reset  in  1  synchronous, active-low reset
enable  in  1  1 = run the I2S clocks and serializer
s_left  in  DATA_WIDTH  left sample, two's complement
s_right  in  DATA_WIDTH  right sample, two's complement
s_valid  in  1  sample pair valid
s_ready  out  1  holding register empty; pair accepted when s_valid && s_ready
ac_bclk  out  1  I2S bit clock to codec
ac_pblrc  out  1  I2S word clock; 0 = left slot, 1 = right slot
ac_pbdat  out  1  I2S serial playback data
frame_start  out  1  one-cycle pulse when a new frame begins (left slot bit 0)
underrun  out  1  one-cycle pulse; frame started with no pair buffered
underrun_count  out  16  saturating count of underruns

Behaviour:
- Reset (reset==0 at a board_clk edge):
  - ac_bclk=0, ac_pblrc=0, ac_pbdat=0, frame_start=0, underrun=0, underrun_count=0, s_ready=1.
  - Holding register empty; shift registers 0; div_cnt=0; bit_cnt=2*SLOT_WIDTH-1.
  - Reset mid-frame aborts immediately: no partial-frame completion, and a buffered pair is discarded.
- Disabled (enable==0): same state as reset, except the holding register and underrun_count are retained. s_ready and the holding register keep working.
- Clock divider:
  - div_cnt counts 0..BCLK_HALF_PERIOD-1.
  - At terminal count: div_cnt->0 and ac_bclk toggles.
  - The terminal count with ac_bclk==1 is a fall event; the terminal count with ac_bclk==0 is a rise event.
  - bclk period = 2*BCLK_HALF_PERIOD board_clk cycles.
- After enable rises, the first bclk edge is a rise; the first fall event starts a frame.
- On each fall event, all of the following are registered in the same cycle as ac_bclk goes low:
  - bit_cnt <= (bit_cnt==2*SLOT_WIDTH-1) ? 0 : bit_cnt+1.
  - ac_pblrc <= (new bit_cnt >= SLOT_WIDTH).
  - With p = new bit_cnt mod SLOT_WIDTH: ac_pbdat = 0 when p==0 (I2S delay bit); shift[DATA_WIDTH-p] of the current channel when 1<=p<=DATA_WIDTH; 0 otherwise.
- Frame start (fall event with new bit_cnt==0):
  - frame_start pulses for that cycle.
  - If the holding register is full, copy it to the left/right shift registers and mark it empty.
  - Otherwise load zeros, pulse underrun, and increment underrun_count, saturating at 16'hFFFF.
- Handshake:
  - s_ready = holding register empty (registered flag).
  - A pair is accepted when s_valid && s_ready; the holding register becomes full on the next cycle.
  - No bypass: a pair accepted in the frame-start cycle of an empty buffer does not play that frame, and the underrun is still flagged.
- Latency: an accepted pair starts on ac_pbdat at the next frame start. MSB appears at left slot bit 1, i.e. one bclk after ac_pblrc falls.
- ac_pbdat, ac_pblrc and ac_bclk change only on board_clk edges and never change on bclk rise events apart from ac_bclk itself. The codec samples on the bclk rising edge.

Decomposition:
- Shared package sampler_audio_pkg holds:
  - I2S_DATA_WIDTH and I2S_SLOT_WIDTH defaults.
  - Typedef stereo_sample_t (packed struct: left, right).
  - UNDERRUN_CNT_W=16.
- Sub-module i2s_clock_gen contains the divider, ac_bclk, bit_cnt, ac_pblrc, and fall/frame_start strobes.
- Top level contains the holding register, shift registers, data mux and underrun logic.

Test Plan:
(All cases use DATA_WIDTH=24, SLOT_WIDTH=32, BCLK_HALF_PERIOD=2, so one frame is 256 board_clk cycles.)
1. Reset check: hold reset low, enable=1 -> all outputs 0, s_ready=1, underrun_count=0. Release reset -> first ac_bclk rise 2 cycles later; first fall (and frame_start) 4 cycles after release.
2. Single pair: push left=24'hA5A5A5, right=24'h800001 before the first frame start -> left slot bits 1..24 = A5A5A5 MSB first, bits 0 and 25..31 = 0; right slot bits 1..24 = 800001; no underrun.
3. Underrun: enable with no pair pushed -> ac_pbdat all 0, underrun pulse at each frame_start. After 3 frames underrun_count=3; s_ready stays 1.
4. Backpressure: push pair A, then hold s_valid with pair B -> s_ready=0 until A's frame_start, then B is accepted on the next cycle. A plays frame N, B plays frame N+1, with no underrun.
5. Saturation: force 65536 underruns with no input -> underrun_count stops at 16'hFFFF.
6. Disable mid-frame: drop enable at bit_cnt=40 with a pair buffered -> ac_bclk, ac_pblrc, ac_pbdat go to 0 on the next cycle; holding register is kept. Re-enable -> the buffered pair plays in the first frame.
